// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: iterative AES-128 key expansion, one round key per clock, using a shared external SubWord unit
module key_schedule_ctrl #(
  parameter int NR = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [0:127]    key,
  output logic [0:31]     sub_in,
  input  logic [0:31]     sub_out,
  output logic            busy,
  output logic            done,
  output logic [0:1407]   keys,
  input  logic [3:0]      rk_sel,
  output logic [0:127]    rk
);
  typedef enum logic [1:0] {IDLE, EXPAND, FIN} state_t;
  localparam logic [3:0] LAST = 4'(NR);
  state_t state, nxt;
  logic [3:0] r, rp;
  logic [7:0] rcon, rcon_nxt;
  logic [10:0] base_prev;
  logic [0:127] p, nk;
  logic [0:31] t, w0, w1, w2, w3;
  // previous round key words and the next round key derived from them
  always_comb begin
    rp = r - 4'd1;
    base_prev = {rp, 7'b0};
    p = (r == 4'd0 || r > LAST) ? '0 : keys[base_prev +: 128];
    t = sub_out ^ {rcon, 24'h0};
    w0 = p[0:31] ^ t;
    w1 = p[32:63] ^ w0;
    w2 = p[64:95] ^ w1;
    w3 = p[96:127] ^ w2;
    nk = {w0, w1, w2, w3};
    rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  end
  // next-state decode and status outputs; the S-box input stays quiet outside EXPAND
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (start ? EXPAND : IDLE) : state == EXPAND ? (r == LAST ? FIN : EXPAND) : IDLE;
    busy = state != IDLE;
    done = state == FIN;
    sub_in = state == EXPAND ? {p[104:127], p[96:103]} : '0;
  end
  // state, round counter, rcon and round-key storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      keys <= '0;
      r <= 4'd0;
      rcon <= 8'h01;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        keys[0:127] <= key;
        r <= 4'd1;
        rcon <= 8'h01;
      end else if (state == EXPAND) begin
        keys[{r, 7'b0} +: 128] <= nk;
        rcon <= rcon_nxt;
        if (r != LAST) r <= r + 4'd1;
      end
    end
  end
  // random-access read port; out-of-range indices read as zero
  always_comb rk = rk_sel > LAST ? '0 : keys[{rk_sel, 7'b0} +: 128];
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb_key_schedule_ctrl: directed self-checking bench with a behavioural S-box on the shared SubWord path
module tb_key_schedule_ctrl;
  logic clk, reset, start, busy, done;
  logic [0:127] key, rk;
  logic [0:31] sub_in, sub_out;
  logic [0:1407] keys;
  logic [3:0] rk_sel;
  int ncmp = 0, nerr = 0;
  int da, bc, dc, d1, d2;
  logic [31:0] s1;
  localparam logic [127:0] FIPS = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] Z1 = 128'h62636363_62636363_62636363_62636363;
  localparam logic [127:0] Z10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;
  localparam logic [127:0] F1 = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] F10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

  key_schedule_ctrl #(.NR(10)) dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .sub_in(sub_in), .sub_out(sub_out),
    .busy(busy), .done(done), .keys(keys), .rk_sel(rk_sel), .rk(rk)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x = a, y = b, q = 0;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) q ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return q;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y = 8'h01;
    for (int i = 0; i < 254; i++) y = gmul(y, x);
    return y ^ rol(y, 1) ^ rol(y, 2) ^ rol(y, 3) ^ rol(y, 4) ^ 8'h63;
  endfunction

  always_comb sub_out = {sbox(sub_in[0:7]), sbox(sub_in[8:15]), sbox(sub_in[16:23]), sbox(sub_in[24:31])};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [127:0] k);
    @(negedge clk);
    key = k;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic measure(output int d_at, output int b_cnt, output int d_cnt, output logic [31:0] first_sub);
    d_at = 0; b_cnt = 0; d_cnt = 0; first_sub = sub_in;
    for (int i = 1; i <= 20; i++) begin
      if (busy) b_cnt++;
      if (done) begin
        d_cnt++;
        if (d_at == 0) d_at = i;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    chk(tag, 128'(done), 128'd1);
    @(negedge clk);
  endtask

  task automatic rd(input string tag, input logic [3:0] sel, input logic [127:0] exp);
    rk_sel = sel;
    #1;
    chk(tag, rk, exp);
  endtask

  initial begin
    reset = 1; start = 0; key = '0; rk_sel = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_done", 128'(done), 0);
    chk("rst_sub_in", 128'(sub_in), 0);
    chk("rst_keys", 128'(|keys), 0);
    reset = 0;
    go('0);
    measure(da, bc, dc, s1);
    chk("zero_done_at", 128'(da), 11);
    chk("zero_busy_cycles", 128'(bc), 11);
    chk("zero_done_count", 128'(dc), 1);
    rd("zero_rk1", 1, Z1);
    rd("zero_rk10", 10, Z10);
    chk("idle_sub_in", 128'(sub_in), 0);
    go(FIPS);
    measure(da, bc, dc, s1);
    chk("fips_first_sub_in", 128'(s1), 128'hcf4f3c09);
    chk("fips_done_count", 128'(dc), 1);
    rd("fips_rk1", 1, F1);
    rd("fips_rk10", 10, F10);
    chk("fips_keys0", keys[0:127], FIPS);
    rd("rk_sel11", 11, 0);
    rd("rk_sel15", 15, 0);
    go('0);
    repeat (3) @(negedge clk);
    key = FIPS;
    start = 1;
    @(negedge clk);
    start = 0;
    key = '0;
    wait_done("ign_done_seen");
    rd("ign_rk0", 0, 0);
    rd("ign_rk1", 1, Z1);
    rd("ign_rk10", 10, Z10);
    @(negedge clk);
    key = FIPS;
    start = 1;
    @(negedge clk);
    d1 = 0; d2 = 0; dc = 0;
    for (int i = 1; i <= 24; i++) begin
      if (done) begin
        dc++;
        if (d1 == 0) d1 = i; else d2 = i;
      end
      @(negedge clk);
    end
    start = 0;
    chk("hold_done_count", 128'(dc), 2);
    chk("hold_spacing", 128'(d2 - d1), 12);
    wait_done("hold_last_done");
    rd("hold_rk10", 10, F10);
    go('0);
    repeat (5) @(negedge clk);
    reset = 1;
    #1;
    chk("abort_busy", 128'(busy), 0);
    chk("abort_done", 128'(done), 0);
    chk("abort_keys", 128'(|keys), 0);
    @(negedge clk);
    reset = 0;
    measure(da, bc, dc, s1);
    chk("abort_no_done", 128'(dc), 0);
    go(FIPS);
    wait_done("after_abort_done");
    rd("after_abort_rk1", 1, F1);
    rd("after_abort_rk10", 10, F10);
    chk("after_abort_keys0", keys[0:127], FIPS);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
